// File: rtl/spi_pkg.sv
// Shared types and parameter legality helper for the SPI controller-side transmitter.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD
  } spi_tx_state_t;

  function automatic bit cfg_ok(input int data_width, input int lines, input int period);
    return (data_width >= 2) && (lines >= 1) && (period >= 4) && ((period % 2) == 0);
  endfunction

endpackage

// File: rtl/spi_send_con_if.sv
// Word hand-off between a producer and the SPI transmitter: valid/ready, one word per line.
interface spi_send_con_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 1
);
  logic [LINES-1:0][DATA_WIDTH-1:0] data_in;
  logic                             data_valid_in;
  logic                             ready_out;

  modport master (output data_in, output data_valid_in, input ready_out);
  modport slave  (input data_in, input data_valid_in, output ready_out);
endinterface

// File: rtl/spi_clk_phase_gen.sv
// DCLK phase counter: counts cycles within one DCLK period and strobes the last cycle of the
// low phase and of the high phase (plus one cycle early for the high phase). Held at zero while cleared.
module spi_clk_phase_gen #(
  parameter int PERIOD = 100,
  parameter int DUTY   = PERIOD / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic low_end,
  output logic high_end,
  output logic high_pre_end
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  assign low_end      = en && (cnt == CW'(DUTY - 1));
  assign high_end     = en && (cnt == CW'(PERIOD - 1));
  assign high_pre_end = en && (cnt == CW'(PERIOD - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= high_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_send_con.sv
// SPI transmitter: CS/DCLK generation, LINES parallel MSB-first shift registers, one-entry next word.
// First DCLK rise DUTY_CYCLE+1 cycles after accept; ready only in IDLE or last-bit HIGH with buffer empty.
module spi_send_con
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int LINES           = 1,
  parameter int DATA_CLK_PERIOD = 100
) (
  input  logic              clk_in,
  input  logic              rst_in,
  spi_send_con_if.slave     bus,
  output logic              busy_out,
  output logic              word_done_out,
  output logic [LINES-1:0]  chip_data_out,
  output logic              chip_clk_out,
  output logic              chip_sel_out
);

  localparam int DUTY_CYCLE = DATA_CLK_PERIOD / 2;
  localparam int BW         = $clog2(DATA_WIDTH + 1);

  if (!cfg_ok(DATA_WIDTH, LINES, DATA_CLK_PERIOD)) begin : g_bad_cfg
    $error("spi_send_con: illegal DATA_WIDTH/LINES/DATA_CLK_PERIOD");
  end

  typedef logic [LINES-1:0][DATA_WIDTH-1:0] word_t;

  spi_tx_state_t state, state_nxt;
  logic [BW-1:0] bit_cnt;
  word_t         shreg;
  word_t         pend;
  logic          pend_vld, pend_vld_nxt;
  logic          ready, ready_nxt;
  logic          done_nxt;
  logic          accept, last_bit;
  logic          load_in, load_pend, shift, store, clear;
  logic          low_end, high_end, high_pre_end;

  assign accept        = bus.data_valid_in & ready;
  assign bus.ready_out = ready;
  assign last_bit      = (bit_cnt == BW'(DATA_WIDTH - 1));

  spi_clk_phase_gen #(
    .PERIOD (DATA_CLK_PERIOD),
    .DUTY   (DUTY_CYCLE)
  ) u_phase (
    .clk          (clk_in),
    .rst          (rst_in),
    .en           (state != IDLE),
    .clr          (state == IDLE),
    .low_end      (low_end),
    .high_end     (high_end),
    .high_pre_end (high_pre_end)
  );

  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
    load_pend = 1'b0;
    shift     = 1'b0;
    store     = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_in   = 1'b1;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (low_end) state_nxt = HIGH;
      end
      HIGH: begin
        if (high_end) begin
          if (!last_bit) begin
            shift     = 1'b1;
            state_nxt = LOW;
          end else if (pend_vld) begin
            load_pend = 1'b1;
            state_nxt = LOW;
          end else if (accept) begin
            // Word offered on the final high cycle goes straight into the shifter.
            load_in   = 1'b1;
            state_nxt = LOW;
          end else begin
            state_nxt = HOLD;
          end
        end else if (accept) begin
          store = 1'b1;
        end
      end
      HOLD: begin
        if (low_end) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    pend_vld_nxt = store | (pend_vld & ~load_pend);
    // Outputs are registered, so they are derived from next-cycle state.
    ready_nxt = (state_nxt == IDLE) |
                ((state_nxt == HIGH) & last_bit & ~pend_vld_nxt);
    done_nxt  = (state == HIGH) & last_bit & high_pre_end;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      pend          <= '0;
      pend_vld      <= 1'b0;
      ready         <= 1'b0;
      busy_out      <= 1'b0;
      word_done_out <= 1'b0;
      chip_clk_out  <= 1'b0;
      chip_sel_out  <= 1'b1;
    end else begin
      state    <= state_nxt;
      pend_vld <= pend_vld_nxt;
      if (store) pend <= bus.data_in;
      if (load_in) begin
        shreg   <= bus.data_in;
        bit_cnt <= '0;
      end else if (load_pend) begin
        shreg   <= pend;
        bit_cnt <= '0;
      end else if (shift) begin
        for (int l = 0; l < LINES; l++) begin
          shreg[l] <= {shreg[l][DATA_WIDTH-2:0], 1'b0};
        end
        bit_cnt <= bit_cnt + 1'b1;
      end else if (clear) begin
        shreg <= '0;
      end
      ready         <= ready_nxt;
      busy_out      <= (state_nxt != IDLE);
      word_done_out <= done_nxt;
      chip_clk_out  <= (state_nxt == HIGH);
      chip_sel_out  <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    for (int l = 0; l < LINES; l++) begin
      chip_data_out[l] = shreg[l][DATA_WIDTH-1];
    end
  end

endmodule

// File: tb/tb_spi_send_con.sv
// Bench for spi_send_con: frame-level model checked every cycle plus directed timing expectations.
module tb_spi_send_con;

  localparam int W = 8;
  localparam int L = 2;
  localparam int P = 4;
  localparam int D = 2;

  typedef logic [L-1:0][W-1:0] w2_t;

  typedef struct packed {
    logic         cs;
    logic         sclk;
    logic [L-1:0] dat;
    logic         rdy;
    logic         busy;
    logic         done;
  } obs_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  spi_send_con_if #(.DATA_WIDTH(W), .LINES(L)) bus1 ();
  logic         busy1, done1, sclk1, cs1;
  logic [L-1:0] sdat1;

  spi_send_con #(.DATA_WIDTH(W), .LINES(L), .DATA_CLK_PERIOD(P)) dut1 (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .bus           (bus1),
    .busy_out      (busy1),
    .word_done_out (done1),
    .chip_data_out (sdat1),
    .chip_clk_out  (sclk1),
    .chip_sel_out  (cs1)
  );

  spi_send_con_if #(.DATA_WIDTH(8), .LINES(1)) bus2 ();
  logic       busy2, done2, sclk2, cs2;
  logic [0:0] sdat2;

  spi_send_con #(.DATA_WIDTH(8), .LINES(1), .DATA_CLK_PERIOD(100)) dut2 (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .bus           (bus2),
    .busy_out      (busy2),
    .word_done_out (done2),
    .chip_data_out (sdat2),
    .chip_clk_out  (sclk2),
    .chip_sel_out  (cs2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Frame model: a frame starts the cycle after an accept in idle and consists of m_n words,
  // each W bit periods of P cycles (low D, then high), followed by D cycles of CS hold.
  int  cyc      = 0;
  bit  armed    = 1'b0;
  bit  m_active = 1'b0;
  int  m_start  = 0;
  int  m_n      = 0;
  w2_t m_words[$];

  function automatic obs_t model_at(input int c);
    obs_t e;
    int rel, total, bi, wi, wd, bt;
    e.cs = 1'b1; e.sclk = 1'b0; e.dat = '0; e.rdy = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    if (rst_in || !armed) return e;
    e.rdy = 1'b1;
    if (m_active) begin
      rel   = c - m_start;
      total = m_n * W * P;
      e.cs = 1'b0; e.busy = 1'b1; e.rdy = 1'b0;
      if (rel < total) begin
        bi = rel / P; wi = rel % P; wd = bi / W; bt = bi % W;
        e.sclk = (wi >= D);
        for (int l = 0; l < L; l++) e.dat[l] = m_words[wd][l][W-1-bt];
        e.done = (bt == W - 1) && (wi == P - 1);
        e.rdy  = (wd == m_n - 1) && (bt == W - 1) && (wi >= D);
      end else begin
        for (int l = 0; l < L; l++) e.dat[l] = m_words[m_n-1][l][0];
      end
    end
    return e;
  endfunction

  always @(posedge clk_in) begin : mdl
    obs_t e;
    if (!rst_in) begin
      e = model_at(cyc);
      if (bus1.data_valid_in && e.rdy) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_start  = cyc + 1;
          m_n      = 1;
          m_words.delete();
        end else begin
          m_n++;
        end
        m_words.push_back(bus1.data_in);
      end
      armed = 1'b1;
    end
    cyc++;
    if (m_active && (cyc - m_start >= m_n * W * P + D)) m_active = 1'b0;
  end

  always @(posedge rst_in) begin
    armed    = 1'b0;
    m_active = 1'b0;
  end

  always @(negedge clk_in) begin : cmp
    obs_t e, a;
    e = model_at(cyc);
    a = {cs1, sclk1, sdat1, bus1.ready_out, busy1, done1};
    check($sformatf("cycle%0d", cyc), a, e);
  end

  // Receiver and event log for DUT1, sampled mid-cycle.
  logic p_sclk = 1'b0;
  logic p_cs   = 1'b1;
  int   rises[$], dones[$], cs_falls[$], cs_rises[$];
  w2_t  rx_words[$];
  w2_t  rx_sh;
  int   rx_n = 0;

  always @(negedge clk_in) begin : obs
    if (rst_in) begin
      rx_n = 0;
    end else begin
      if (sclk1 && !p_sclk) begin
        rises.push_back(cyc);
        for (int l = 0; l < L; l++) rx_sh[l] = {rx_sh[l][W-2:0], sdat1[l]};
        rx_n++;
        if (rx_n == W) begin
          rx_words.push_back(rx_sh);
          rx_n = 0;
        end
      end
      if (done1) dones.push_back(cyc);
      if (!cs1 && p_cs) cs_falls.push_back(cyc);
      if (cs1 && !p_cs) cs_rises.push_back(cyc);
    end
    p_sclk = sclk1;
    p_cs   = cs1;
  end

  task automatic clear_logs();
    rises.delete(); dones.delete(); cs_falls.delete(); cs_rises.delete(); rx_words.delete();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Called #1 after a posedge; returns the accept cycle.
  task automatic send1(input w2_t w, output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    bus1.data_valid_in = 1'b1;
    bus1.data_in       = w;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_in);
      if (bus1.ready_out) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    check("accept_within_budget", got, 1);
    @(posedge clk_in);
    #1;
    bus1.data_valid_in = 1'b0;
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic w2_t wat(input w2_t q[$], input int i);
    return (i < q.size()) ? q[i] : '1;
  endfunction

  initial begin : stim
    int t1, t2, cur, bad_run, cs_low, bad_dat, n_done2;
    bit got;
    logic ps, pd, pc;
    logic [7:0] rx2;
    bit lv[$];
    int runs[$];

    bus1.data_valid_in = 1'b0;
    bus1.data_in       = '0;
    bus2.data_valid_in = 1'b0;
    bus2.data_in       = '0;

    #8;
    check("rst_cs", cs1, 1);
    check("rst_sclk", sclk1, 0);
    check("rst_data", sdat1, 0);
    check("rst_ready", bus1.ready_out, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    #4 rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    check("ready_after_rst", bus1.ready_out, 1);
    wait_until(cyc + 2);

    // Single word
    clear_logs();
    send1({8'hA5, 8'h3C}, t1);
    wait_until(t1 + 40);
    check("t1_cs_fall", qat(cs_falls, 0), t1 + 1);
    check("t1_rise_count", rises.size(), 8);
    check("t1_rise0", qat(rises, 0), t1 + 3);
    check("t1_rise7", qat(rises, 7), t1 + 31);
    check("t1_done_count", dones.size(), 1);
    check("t1_done_cycle", qat(dones, 0), t1 + 32);
    check("t1_cs_rise", qat(cs_rises, 0), t1 + 35);
    check("t1_rx_word", wat(rx_words, 0), 16'hA53C);

    // Back-to-back through the buffer
    clear_logs();
    send1({8'h5A, 8'hC3}, t1);
    wait_until(t1 + 31);
    send1({8'h81, 8'h7E}, t2);
    check("t2_accept_cycle", t2, t1 + 31);
    wait_until(t1 + 75);
    check("t2_rise_count", rises.size(), 16);
    check("t2_rise8", qat(rises, 8), t1 + 35);
    check("t2_done_count", dones.size(), 2);
    check("t2_done1", qat(dones, 1), t1 + 64);
    check("t2_cs_fall_count", cs_falls.size(), 1);
    check("t2_cs_rise", qat(cs_rises, 0), t1 + 67);
    check("t2_rx0", wat(rx_words, 0), 16'h5AC3);
    check("t2_rx1", wat(rx_words, 1), 16'h817E);

    // Accept on the final high cycle loads directly
    clear_logs();
    send1({8'h0F, 8'hF0}, t1);
    wait_until(t1 + 32);
    send1({8'h69, 8'h96}, t2);
    check("t2b_accept_cycle", t2, t1 + 32);
    wait_until(t1 + 75);
    check("t2b_rise8", qat(rises, 8), t1 + 35);
    check("t2b_cs_fall_count", cs_falls.size(), 1);
    check("t2b_rx1", wat(rx_words, 1), 16'h6996);

    // Valid raised during HOLD waits for IDLE
    clear_logs();
    send1({8'h12, 8'h34}, t1);
    wait_until(t1 + 33);
    send1({8'hC0, 8'hDE}, t2);
    check("t3_accept_cycle", t2, t1 + 35);
    wait_until(t1 + 80);
    check("t3_cs_rise", qat(cs_rises, 0), t1 + 35);
    check("t3_cs_fall_count", cs_falls.size(), 2);
    check("t3_cs_fall1", qat(cs_falls, 1), t1 + 36);
    check("t3_rx1", wat(rx_words, 1), 16'hC0DE);

    // Asynchronous reset mid-bit 4
    clear_logs();
    send1({8'h3C, 8'hA5}, t1);
    wait_until(t1 + 18);
    #3 rst_in = 1'b1;
    #1;
    check("t4_cs", cs1, 1);
    check("t4_sclk", sclk1, 0);
    check("t4_data", sdat1, 0);
    check("t4_busy", busy1, 0);
    check("t4_ready", bus1.ready_out, 0);
    check("t4_done", done1, 0);
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    wait_until(cyc + 40);
    check("t4_no_done", dones.size(), 0);
    clear_logs();
    send1({8'h99, 8'h66}, t2);
    wait_until(t2 + 40);
    check("t4_restart_rx", wat(rx_words, 0), 16'h9966);
    check("t4_restart_done", dones.size(), 1);

    // Long period, one line
    bus2.data_valid_in = 1'b1;
    bus2.data_in       = 8'hFF;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_in);
      if (bus2.ready_out) got = 1'b1;
    end
    check("t5_accept", got, 1);
    @(posedge clk_in);
    #1;
    bus2.data_valid_in = 1'b0;
    ps = 1'b0; pd = 1'b0; pc = 1'b1;
    rx2 = '0; cs_low = 0; bad_dat = 0; n_done2 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (!cs2) begin
        cs_low++;
        lv.push_back(sclk2);
        if (sclk2 && !ps) rx2 = {rx2[6:0], sdat2[0]};
      end
      if (done2) n_done2++;
      if ((sdat2[0] != pd) && !(ps && !sclk2) && (cs2 == pc)) bad_dat++;
      ps = sclk2; pd = sdat2[0]; pc = cs2;
    end
    cur = 0;
    foreach (lv[i]) begin
      if (i > 0 && lv[i] != lv[i-1]) begin
        runs.push_back(cur);
        cur = 0;
      end
      cur++;
    end
    if (cur > 0) runs.push_back(cur);
    bad_run = 0;
    foreach (runs[i]) if (runs[i] != 50) bad_run++;
    check("t5_first_level_low", (lv.size() > 0) ? lv[0] : 1'b1, 0);
    check("t5_run_count", runs.size(), 17);
    check("t5_bad_runs", bad_run, 0);
    check("t5_cs_low_cycles", cs_low, 850);
    check("t5_bad_data_edges", bad_dat, 0);
    check("t5_rx", rx2, 8'hFF);
    check("t5_done_count", n_done2, 1);
    check("t5_idle_cs", cs2, 1);
    check("t5_idle_data", sdat2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
